// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding, port IDs and latency-counter sizing for the memory arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, HALTED} state_t;
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;
    localparam int CNT_W = 4;
    // Loaded as LATENCY-1 so the counter reads zero in the cycle mem_rdata is valid
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        return CNT_W'(lat - 1);
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data-memory, halt and memory-port signals of the arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;
    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              dm_stall;
    logic              err;
    logic              halt;
    logic              halted;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt, mem_rdata,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall, err, halted,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, halt, mem_rdata,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall, err, halted,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_lat_cnt.sv
// mem_lat_cnt: loadable down-counter that stops at zero and flags it
module mem_lat_cnt
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        cnt <= rst ? '0 : load ? val : (dec && !zero) ? cnt - 1'b1 : cnt;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants one shared fixed-latency memory port to fetch or data access, data first
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    state_t state, state_nxt;
    logic hlt, zero, idle, dm_elig, if_elig, gnt_dm, gnt_if, flt, issue, sel;
    assign idle    = state == IDLE || state == HALTED;
    assign dm_elig = (bus.dm_rd || bus.dm_wr) && !bus.dm_done;
    assign if_elig = bus.if_req && !bus.if_done && !bus.halt && state != HALTED;
    assign gnt_dm  = idle && dm_elig;
    assign gnt_if  = idle && !dm_elig && if_elig;
    assign sel     = gnt_dm ? PORT_DM : PORT_IF;
    // A faulted grant never reaches memory; it only earns a done+err pulse
    assign flt     = gnt_dm ? (bus.dm_addr[0] || (bus.dm_rd && bus.dm_wr)) : (gnt_if && bus.if_addr[0]);
    assign issue   = (gnt_dm || gnt_if) && !flt;
    mem_lat_cnt u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (issue),
        .dec  (state == BUSY_IF || state == BUSY_DM),
        .val  (lat_load(LATENCY)),
        .zero (zero)
    );
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
        hlt   <= !rst && (hlt || state == HALTED);
    end
    always_comb begin
        state_nxt = issue ? (sel == PORT_DM ? BUSY_DM : BUSY_IF)
                  : idle  ? ((state == HALTED || (bus.halt && !dm_elig)) ? HALTED : IDLE)
                  : zero  ? (hlt ? HALTED : IDLE)
                  : state;
    end
    always_comb begin
        bus.mem_en    = issue;
        bus.mem_wr    = issue && sel == PORT_DM && bus.dm_wr;
        bus.mem_addr  = !issue ? '0 : sel == PORT_DM ? bus.dm_addr : bus.if_addr;
        bus.mem_wdata = (issue && sel == PORT_DM) ? bus.dm_wdata : '0;
        bus.halted    = state == HALTED;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.if_done  <= 1'b0;
            bus.dm_done  <= 1'b0;
            bus.err      <= 1'b0;
            bus.if_rdata <= '0;
            bus.dm_rdata <= '0;
        end else begin
            bus.if_done <= (state == BUSY_IF && zero) || (gnt_if && flt);
            bus.dm_done <= (state == BUSY_DM && zero) || (gnt_dm && flt);
            bus.err     <= flt;
            if (state == BUSY_IF && zero) bus.if_rdata <= bus.mem_rdata;
            if (state == BUSY_DM && zero && !bus.dm_wr) bus.dm_rdata <= bus.mem_rdata;
        end
    end
    assign bus.if_stall = bus.if_req && !bus.if_done;
    assign bus.dm_stall = (bus.dm_rd || bus.dm_wr) && !bus.dm_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latency, faults, halt and reset for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;
    localparam int LAT = 4;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_ok = 0;
    logic        v [LAT];
    logic [15:0] a [LAT];
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    mem_port_arbiter #(.LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [15:0] mem_data(input logic [15:0] addr);
        case (addr)
            16'h0010: return 16'hA5A5;
            16'h0020: return 16'h5A5A;
            16'h0200: return 16'h1234;
            16'h0300: return 16'hBEEF;
            default:  return 16'hDEAD;
        endcase
    endfunction
    // Memory model: data for an issued address appears exactly LAT cycles later, 0xFFFF otherwise
    always @(posedge clk) begin
        v[0] <= bus.mem_en;
        a[0] <= bus.mem_addr;
        for (int i = 1; i < LAT; i++) begin
            v[i] <= v[i-1];
            a[i] <= a[i-1];
        end
    end
    assign bus.mem_rdata = v[LAT-1] ? mem_data(a[LAT-1]) : 16'hFFFF;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_ok++;
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    initial begin
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.dm_rd = 0; bus.dm_wr = 0;
        bus.dm_addr = 0; bus.dm_wdata = 0; bus.halt = 0;
        step(3); #1;
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_if_done", bus.if_done, 0);
        chk("rst_dm_done", bus.dm_done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        chk("rst_if_stall", bus.if_stall, 0);
        rst = 1'b0;
        step(1);
        bus.if_req = 1; bus.if_addr = 16'h0010; #1;
        chk("f_mem_en", bus.mem_en, 1);
        chk("f_mem_addr", bus.mem_addr, 16'h0010);
        chk("f_mem_wr", bus.mem_wr, 0);
        chk("f_stall_t0", bus.if_stall, 1);
        step(4); #1;
        chk("f_done_t4", bus.if_done, 0);
        chk("f_stall_t4", bus.if_stall, 1);
        chk("f_mem_en_t4", bus.mem_en, 0);
        step(1); #1;
        chk("f_done_t5", bus.if_done, 1);
        chk("f_rdata", bus.if_rdata, 16'hA5A5);
        chk("f_stall_t5", bus.if_stall, 0);
        chk("f_no_regrant", bus.mem_en, 0);
        bus.if_req = 0;
        step(1); #1;
        chk("f_done_pulse", bus.if_done, 0);
        bus.if_req = 1; bus.if_addr = 16'h0020; bus.dm_rd = 1; bus.dm_addr = 16'h0200; #1;
        chk("both_mem_en", bus.mem_en, 1);
        chk("both_dm_first", bus.mem_addr, 16'h0200);
        step(5); #1;
        chk("both_dm_done", bus.dm_done, 1);
        chk("both_dm_rdata", bus.dm_rdata, 16'h1234);
        chk("both_if_wait", bus.if_done, 0);
        chk("both_if_mem_en", bus.mem_en, 1);
        chk("both_if_addr", bus.mem_addr, 16'h0020);
        bus.dm_rd = 0;
        step(5); #1;
        chk("both_if_done", bus.if_done, 1);
        chk("both_if_rdata", bus.if_rdata, 16'h5A5A);
        chk("both_dm_pulse", bus.dm_done, 0);
        bus.if_req = 0;
        step(1);
        bus.dm_wr = 1; bus.dm_addr = 16'h0041; bus.dm_wdata = 16'h7777; #1;
        chk("flt_no_mem_en", bus.mem_en, 0);
        step(1); #1;
        chk("flt_done", bus.dm_done, 1);
        chk("flt_err", bus.err, 1);
        chk("flt_rdata_kept", bus.dm_rdata, 16'h1234);
        bus.dm_wr = 0;
        step(1); #1;
        chk("flt_err_pulse", bus.err, 0);
        chk("flt_done_pulse", bus.dm_done, 0);
        bus.if_req = 1; bus.if_addr = 16'h0010; #1;
        chk("h_mem_en", bus.mem_en, 1);
        step(1);
        bus.halt = 1;
        step(4); #1;
        chk("h_if_done", bus.if_done, 1);
        chk("h_not_yet", bus.halted, 0);
        bus.if_req = 0;
        step(1); #1;
        chk("h_halted", bus.halted, 1);
        bus.if_req = 1; bus.if_addr = 16'h0020; #1;
        chk("h_fetch_blocked", bus.mem_en, 0);
        step(2); #1;
        chk("h_fetch_blocked2", bus.mem_en, 0);
        chk("h_no_if_done", bus.if_done, 0);
        bus.dm_rd = 1; bus.dm_addr = 16'h0300; #1;
        chk("h_dm_mem_en", bus.mem_en, 1);
        chk("h_dm_addr", bus.mem_addr, 16'h0300);
        step(1); #1;
        chk("h_busy_halted", bus.halted, 0);
        chk("h_dm_stall", bus.dm_stall, 1);
        step(4); #1;
        chk("h_dm_done", bus.dm_done, 1);
        chk("h_dm_rdata", bus.dm_rdata, 16'hBEEF);
        chk("h_rehalted", bus.halted, 1);
        bus.dm_rd = 0;
        step(1); #1;
        chk("h_still_blocked", bus.mem_en, 0);
        bus.if_req = 0; bus.halt = 0; rst = 1;
        step(1);
        rst = 0; #1;
        chk("r_unhalted", bus.halted, 0);
        bus.dm_rd = 1; bus.dm_addr = 16'h0200; #1;
        chk("r_mem_en", bus.mem_en, 1);
        step(2);
        rst = 1;
        step(1);
        rst = 0; bus.dm_addr = 16'h0010; #1;
        chk("r_no_done", bus.dm_done, 0);
        chk("r_rdata_clr", bus.dm_rdata, 0);
        chk("r_new_mem_en", bus.mem_en, 1);
        chk("r_new_addr", bus.mem_addr, 16'h0010);
        step(4); #1;
        chk("r_done_t7", bus.dm_done, 0);
        step(1); #1;
        chk("r_done_t8", bus.dm_done, 1);
        chk("r_rdata_t8", bus.dm_rdata, 16'hA5A5);
        bus.dm_rd = 0;
        step(1);
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
